// File: rtl/temporal_decoder.sv
// Temporal N-gram decoder: recovers X_t from Y_t = X_t ^ rho(X_t-1) ^ ... using its own
// history of decoded samples, behind a one-entry valid/ready output register.
`ifndef HV_DIMENSION
`define HV_DIMENSION 2048
`endif
`ifndef NGRAM_SIZE
`define NGRAM_SIZE 3
`endif

module temporal_decoder #(
    parameter int HV_DIMENSION = `HV_DIMENSION,
    parameter int NGRAM_SIZE   = `NGRAM_SIZE,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic                    Clear_SI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [0:HV_DIMENSION-1] HypervectorOut_DO,
    output logic                    Primed_SO,
    output logic [CNT_WIDTH-1:0]    SampleCnt_DO
);
    localparam int D  = HV_DIMENSION;
    localparam int NH = NGRAM_SIZE - 1;
    localparam int WW = (NGRAM_SIZE > 2) ? $clog2(NGRAM_SIZE) : 1;

    typedef enum logic {EMPTY, FULL} state_e;

    state_e           state_q, state_d;
    logic [0:D-1]     out_q, out_d;
    logic [0:D-1]     hist_q [NH];
    logic [0:D-1]     hist_d [NH];
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WW-1:0]    warm_q, warm_d;
    logic [0:D-1]     x;
    logic             ready, accept;

    // Index 0 is the MSB, so this is a one-bit right rotate of the numeric value.
    function automatic logic [0:D-1] rho(input logic [0:D-1] v);
        return {v[D-1], v[0:D-2]};
    endfunction

    always_comb begin
        x = HypervectorIn_DI;
        for (int k = 0; k < NH; k++) x = x ^ hist_q[k];

        ready  = (state_q == EMPTY) | ReadyIn_SI;
        accept = ValidIn_SI & ready;

        state_d = state_q;
        out_d   = out_q;
        hist_d  = hist_q;
        cnt_d   = cnt_q;
        warm_d  = warm_q;

        case (state_q)
            EMPTY:   if (ValidIn_SI) state_d = FULL;
            FULL:    if (ReadyIn_SI && !ValidIn_SI) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase

        if (accept) begin
            out_d     = x;
            hist_d[0] = rho(x);
            for (int k = 1; k < NH; k++) hist_d[k] = rho(hist_q[k-1]);
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (warm_q != WW'(NH)) warm_d = warm_q + WW'(1);
        end

        // Clear overrides the history/counter updates of a coincident accept,
        // but the output register still takes the value decoded against old history.
        if (Clear_SI) begin
            for (int k = 0; k < NH; k++) hist_d[k] = '0;
            cnt_d  = '0;
            warm_d = '0;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state_q <= EMPTY;
            out_q   <= '0;
            for (int k = 0; k < NH; k++) hist_q[k] <= '0;
            cnt_q   <= '0;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            hist_q  <= hist_d;
            cnt_q   <= cnt_d;
            warm_q  <= warm_d;
        end
    end

    assign ReadyOut_SO       = ready;
    assign ValidOut_SO       = (state_q == FULL);
    assign HypervectorOut_DO = out_q;
    assign Primed_SO         = (warm_q == WW'(NH));
    assign SampleCnt_DO      = cnt_q;

endmodule

// File: tb/tb_temporal_decoder.sv
// Bench for temporal_decoder (D=8, N=3): directed vectors, a sample-level model,
// and a bench-side encoder feeding randomly throttled traffic.
module tb_temporal_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1, clr = 1'b0, vin = 1'b0, rin = 1'b0;
    logic [7:0] din = '0;
    logic       rdy, vout, primed;
    logic [7:0] dout;
    logic [15:0] cnt;

    temporal_decoder #(.HV_DIMENSION(8), .NGRAM_SIZE(3), .CNT_WIDTH(16)) dut (
        .Clk_CI(clk), .Reset_RI(rst), .Clear_SI(clr), .ValidIn_SI(vin),
        .ReadyOut_SO(rdy), .HypervectorIn_DI(din), .ValidOut_SO(vout),
        .ReadyIn_SI(rin), .HypervectorOut_DO(dout), .Primed_SO(primed),
        .SampleCnt_DO(cnt)
    );

    always #5 clk = ~clk;

    int nchk = 0, nfail = 0;
    // Model: previously decoded samples (unrotated), output slot, counts since reset/clear.
    logic [7:0] px1 = '0, px2 = '0, m_out = '0;
    logic       m_valid = 1'b0;
    int         m_cnt = 0, m_warm = 0;
    bit         started = 0, rt_on = 0;
    logic [7:0] rtq [$];

    function automatic logic [7:0] rotk(input logic [7:0] v, input int k);
        for (int i = 0; i < k; i++) v = {v[0], v[7:1]};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: advance the model with the inputs seen at this edge, then move off the edge.
    task automatic step();
        logic acc;
        logic [7:0] x;
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_out = '0; px1 = '0; px2 = '0; m_cnt = 0; m_warm = 0;
            started = 1;
        end else begin
            acc = vin && (!m_valid || rin);
            x   = din ^ rotk(px1, 1) ^ rotk(px2, 2);
            if (acc) m_out = x;
            if (clr) begin
                px1 = '0; px2 = '0; m_cnt = 0; m_warm = 0;
            end else if (acc) begin
                px2 = px1; px1 = x; m_cnt++; m_warm++;
            end
            m_valid = acc ? 1'b1 : (rin ? 1'b0 : m_valid);
        end
        #1;
    endtask

    initial forever begin
        @(negedge clk);
        if (started) begin
            check("ready", {31'b0, rdy}, {31'b0, (!m_valid || rin)});
            check("valid", {31'b0, vout}, {31'b0, m_valid});
            if (m_valid) check("data", {24'b0, dout}, {24'b0, m_out});
            check("count", {16'b0, cnt}, m_cnt & 32'hFFFF);
            check("primed", {31'b0, primed}, {31'b0, m_warm >= 2});
            if (rt_on && vout && rin) begin
                if (rtq.size() == 0) check("rt_extra", 32'd1, 32'd0);
                else check("rt_data", {24'b0, dout}, {24'b0, rtq.pop_front()});
            end
        end
    end

    initial begin
        logic [7:0] held, x, y, e1, e2;
        int nv, sent;
        bit pending;

        // Reset and first two samples.
        rst = 1; step(); rst = 0;
        check("rst_valid", {31'b0, vout}, 32'd0);
        check("rst_ready", {31'b0, rdy}, 32'd1);
        vin = 1; rin = 1; din = 8'hA5; step();
        check("t1_out", {24'b0, dout}, 32'hA5);
        check("t1_primed", {31'b0, primed}, 32'd0);
        din = 8'h00; step();
        check("t2_out", {24'b0, dout}, 32'hD2);
        check("t2_primed", {31'b0, primed}, 32'd1);
        check("t2_cnt", {16'b0, cnt}, 32'd2);

        // Clear coincident with accept: H1=0F, H2=0.
        rst = 1; step(); rst = 0;
        din = 8'h1E; step();
        clr = 1; din = 8'h3C; step(); clr = 0;
        check("clr_out", {24'b0, dout}, 32'h33);
        check("clr_cnt", {16'b0, cnt}, 32'd0);
        check("clr_primed", {31'b0, primed}, 32'd0);
        din = 8'h5A; step();
        check("clr_pass", {24'b0, dout}, 32'h5A);

        // Backpressure for 5 cycles with a pending input.
        din = 8'h77; step();
        held = dout;
        check("bp_load", {24'b0, held}, 32'h5A);
        rin = 0; din = 8'h11;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_ready", {31'b0, rdy}, 32'd0);
            check("bp_hold", {24'b0, dout}, {24'b0, held});
        end
        rin = 1; step();
        check("bp_release", {24'b0, dout}, 32'hAA);

        // Back-to-back: 16 outputs on 16 consecutive cycles.
        nv = 0;
        for (int i = 0; i < 16; i++) begin
            din = 8'(i * 37 + 5); step();
            if (vout) nv++;
        end
        check("b2b_count", nv, 32'd16);
        vin = 0; step(); step();
        check("b2b_drain", {31'b0, vout}, 32'd0);

        // Round trip through a bench-side encoder with random valid/ready.
        clr = 1; step(); clr = 0;
        rt_on = 1; e1 = '0; e2 = '0; sent = 0; pending = 0; x = '0; y = '0;
        for (int c = 0; c < 3000 && sent < 300; c++) begin
            if (!pending) begin
                x = 8'($urandom);
                y = x ^ rotk(e1, 1) ^ rotk(e2, 2);
                pending = 1;
            end
            din = y; vin = ($urandom_range(3) != 0); rin = ($urandom_range(3) != 0);
            if (vin && (!m_valid || rin)) begin
                rtq.push_back(x); e2 = e1; e1 = x; pending = 0; sent++;
            end
            step();
        end
        vin = 0; rin = 1;
        for (int i = 0; i < 4; i++) step();
        check("rt_sent", sent, 32'd300);
        check("rt_drained", rtq.size(), 32'd0);
        rt_on = 0;

        // Reset while full and stalled.
        vin = 1; rin = 1; din = 8'h99; step();
        rin = 0; step();
        rst = 1; step(); rst = 0;
        check("rst2_valid", {31'b0, vout}, 32'd0);
        check("rst2_ready", {31'b0, rdy}, 32'd1);
        check("rst2_cnt", {16'b0, cnt}, 32'd0);
        rin = 1; din = 8'hC3; step();
        check("rst2_pass", {24'b0, dout}, 32'hC3);
        vin = 0; step();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/temporal_decoder.md
Name: temporal_decoder

Overview:
- Inverse of the temporal N-gram encoder. It recovers each per-sample hypervector X_t from the encoded N-gram stream Y_t = X_t ^ rho(X_t-1) ^ ... ^ rho^(N-1)(X_t-N+1).
- Keeps its own history of already-decoded samples. Sits downstream of the encoder, or after an associative-memory read-back, for reconstruction and for self-check of the encoding path.
- Full-throughput valid/ready stage with a one-entry output register.

Parameters:
- HV_DIMENSION, default `HV_DIMENSION (const.vh): hypervector width D, in bits.
- NGRAM_SIZE, default `NGRAM_SIZE (const.vh): N-gram length N. Must be 2 or more.
- CNT_WIDTH, default 16: width of the sample counter.

Ports:
- Clk_CI  in  1  clock, rising edge.
- Reset_RI  in  1  synchronous, active-high reset.
- Clear_SI  in  1  synchronous history clear, used for resync at record boundaries.
- ValidIn_SI  in  1  upstream N-gram valid.
- ReadyOut_SO  out  1  decoder can accept an input this cycle.
- HypervectorIn_DI  in  [0:D-1]  encoded N-gram Y_t.
- ValidOut_SO  out  1  decoded output valid.
- ReadyIn_SI  in  1  downstream ready.
- HypervectorOut_DO  out  [0:D-1]  decoded sample X_t, registered.
- Primed_SO  out  1  at least N-1 samples decoded since reset/clear, so the history is fully populated.
- SampleCnt_DO  out  CNT_WIDTH  count of accepted inputs since reset/clear.

Behaviour:
- Clock and reset: one clock, Clk_CI. Reset_RI is synchronous and active-high.
- Rotate rho(v) = {v[D-1], v[0:D-2]}. Index 0 is the MSB, so rho is a one-bit right rotate of the numeric value.
- History registers H[1..N-1]:
  - Decode: X = Y ^ H[1] ^ ... ^ H[N-1], combinational from HypervectorIn_DI.
  - On accept: H[1] <= rho(X) and H[k] <= rho(H[k-1]) for k = 2..N-1. Otherwise hold.
- FSM states:
  - EMPTY: ValidOut_SO = 0, ReadyOut_SO = 1. If ValidIn_SI, accept: load output register with X, update history, go to FULL.
  - FULL: ValidOut_SO = 1, ReadyOut_SO = ReadyIn_SI.
    - ReadyIn_SI & ValidIn_SI: output consumed and a new X loaded in the same cycle; stay FULL.
    - ReadyIn_SI & !ValidIn_SI: go to EMPTY.
    - !ReadyIn_SI: hold output and history; stay FULL.
- Latency: output is visible one cycle after acceptance. Sustained throughput is one sample per cycle.
- Ordering rules:
  - An input is accepted only when ValidIn_SI & ReadyOut_SO.
  - HypervectorOut_DO must stay stable while ValidOut_SO & !ReadyIn_SI.
  - ReadyOut_SO never depends on ValidIn_SI.
- Reset values: FSM EMPTY; H[*] = 0; output register = 0; ValidOut_SO = 0; ReadyOut_SO = 1 from the first cycle after reset; Primed_SO = 0; SampleCnt_DO = 0.
- Clear_SI:
  - Zeroes H[*], SampleCnt_DO and the warm-up counter next cycle.
  - Does not touch the FSM, the output register or ValidOut_SO.
  - Clear together with an accept in the same cycle: the input is decoded against the old history and the output is loaded. The history ends at zero and the count ends at 0, because clear wins for those registers.
- SampleCnt_DO: increments on each accept and wraps modulo 2^CNT_WIDTH.
- Primed_SO: driven by a separate warm-up counter that saturates at N-1. High when that counter equals N-1. It does not fall when SampleCnt_DO wraps.
- Reset mid-transfer: a held output is discarded; there is no partial state.

Test Plan:
- D=8, N=3, after reset: Y=8'hA5 -> X=8'hA5, out 1 cycle later, Primed_SO=0. Next Y=8'h00 -> X=8'hD2, since H[1]=rho(A5)=D2. After the second accept Primed_SO=1 and SampleCnt_DO=2.
- Round trip: temporal encoder feeding this decoder, 1000 random D=2048 samples, random valid/ready -> decoded stream equals encoder input stream bit-exactly, in order, with no drops or duplicates.
- Backpressure: ReadyIn_SI=0 for 5 cycles with ValidIn_SI=1 -> ReadyOut_SO=0, output and history frozen. On release, the next accept decodes correctly.
- Back-to-back: ValidIn_SI and ReadyIn_SI held high for 16 cycles -> 16 outputs on 16 consecutive cycles after the 1-cycle latency.
- Clear coincident with accept of Y=8'h3C when H[1]=8'h0F and H[2]=0 -> output 8'h33. Afterwards H=0, SampleCnt_DO=0, Primed_SO=0. The next Y passes through unchanged.
- Reset asserted while FULL and stalled -> next cycle ValidOut_SO=0, ReadyOut_SO=1, SampleCnt_DO=0. The first subsequent Y decodes as itself.
